fx_rob_tag_alloc: RTL
=====================

# fx_rob_tag_alloc

Allocates reorder-buffer entry tags for up to four instructions per cycle in the fixed-point out-of-order pipeline, ahead of the FXRAT stage. Each allocated tag is passed to the FXRAT as the rename target for the instruction's destination registers. The ROB is managed as a circular buffer with a head (oldest) pointer, a tail (next free) pointer and an occupancy count. Retirement frees entries in order from the head, and a flush discards every in-flight entry.

## Interface
- ROBEntryWidth, 7: tag width; numEntries = 2**ROBEntryWidth (128 by default).
- clock_i  in  1  sole clock; all state updates on the rising edge.
- reset_i  in  1  reset, asynchronous and active-low.
- enable_i  in  1  gates allocation and retirement; flush is not gated.
- alloc_i  in  1  allocation request this cycle.
- numInst_i  in  2  request size minus one (00 = 1 tag … 11 = 4 tags).
- retire_i  in  1  retirement request this cycle.
- retireNum_i  in  2  number of entries to free minus one.
- flush_i  in  1  discard all in-flight entries.
- allocValid_o  out  1  grant pulse; tags below are valid.
- numInst_o  out  2  granted count minus one.
- inst1RobId_o … inst4RobId_o  out  ROBEntryWidth  allocated tags, oldest first.
- stall_o  out  1  pulses when a request is refused because there is not enough space.
- retireErr_o  out  1  pulses when a retire request would underflow the buffer.
- freeCount_o  out  ROBEntryWidth+1  free entries.
- full_o, empty_o  out  1  count == numEntries / count == 0.

## Operation
- State: head, tail (ROBEntryWidth bits each, wrapping modulo numEntries) and count (ROBEntryWidth+1 bits).
- Define reqN = numInst_i+1, retN = retireNum_i+1 and cnt = count at the start of the cycle.
- Allocation is accepted when enable_i && alloc_i && !flush_i && (numEntries − cnt) ≥ reqN.
  - Space is checked against the count at the start of the cycle; entries retired in the same cycle do not help.
  - On accept: tags are tail, tail+1, … tail+reqN−1, each mod numEntries. Tag slots beyond reqN output 0. tail advances by reqN.
  - If enable_i && alloc_i && !flush_i but space is insufficient: nothing is allocated (all-or-nothing), and stall_o pulses.
- Retirement is accepted when enable_i && retire_i && retN ≤ cnt. On accept, head advances by retN.
  - If retN > cnt: the request is ignored, state is unchanged, and retireErr_o pulses.
- Accepted allocation and retirement in the same cycle both apply: count_next = cnt + reqN − retN.
- Flush (flush_i=1) applies on any cycle, whatever enable_i is:
  - An accepted retire in the same cycle applies first.
  - Then tail is set to the new head and count to 0.
  - Allocation is suppressed; allocValid_o and stall_o stay 0.
- freeCount_o, full_o and empty_o are combinational from the registered count.

## Timing
- Grant latency is 1 cycle. A request sampled at edge N produces allocValid_o, numInst_o and the tags during the cycle after edge N.
- allocValid_o, stall_o and retireErr_o are single-cycle pulses, deasserted on any cycle with no corresponding event. Tag outputs hold their last values when not valid.
- freeCount_o, full_o and empty_o reflect the count after the edge.
- Back-to-back requests are accepted every cycle while space permits. No request is queued; a refused request must be re-presented by upstream.
- Reset (reset_i=0) acts immediately, without waiting for a clock edge, including mid-operation:
  - head=tail=0, count=0.
  - allocValid_o=0, numInst_o=0, all tags 0, stall_o=0, retireErr_o=0.
  - freeCount_o=numEntries, full_o=0, empty_o=1.
  - Normal operation resumes at the first rising edge after reset_i returns to 1.

## Test plan
- Reset then single request: alloc_i=1, numInst_i=11 → next cycle allocValid_o=1, numInst_o=11, tags 0,1,2,3; freeCount_o=124.
- Fill: issue 32 requests of 4 back-to-back → the last grant has tags 124–127 and full_o=1. A 33rd request → stall_o=1, allocValid_o=0, state unchanged.
- Full with simultaneous retire and alloc: count=128; retire 4 plus alloc 1 in the same cycle → alloc refused (stall_o=1), head=4, freeCount_o=4.
- Wrap-around: head=tail=126, count=0; alloc 4 → tags 126,127,0,1; tail=2; freeCount_o=124.
- Underflow and flush: count=2; retireNum_i=10 (retire 3) → retireErr_o=1, count stays 2. Then flush_i=1 together with alloc 1 → no grant, empty_o=1, tail=head. The next alloc grants the tag equal to head.
- Asynchronous reset: reset_i driven low between edges while count=50 → all outputs take their reset values immediately, with no clock edge. After release, the first alloc returns tag 0.

Source files
------------

// File: rtl/fx_rob_tag_alloc_if.sv
// rtl/fx_rob_tag_alloc_if.sv - request/grant bundle for the ROB tag allocator
interface fx_rob_tag_alloc_if #(
  parameter int ROBEntryWidth = 7
);
  logic                     enable_i;
  logic                     alloc_i;
  logic [1:0]               numInst_i;
  logic                     retire_i;
  logic [1:0]               retireNum_i;
  logic                     flush_i;

  logic                     allocValid_o;
  logic [1:0]               numInst_o;
  logic [ROBEntryWidth-1:0] inst1RobId_o;
  logic [ROBEntryWidth-1:0] inst2RobId_o;
  logic [ROBEntryWidth-1:0] inst3RobId_o;
  logic [ROBEntryWidth-1:0] inst4RobId_o;
  logic                     stall_o;
  logic                     retireErr_o;
  logic [ROBEntryWidth:0]   freeCount_o;
  logic                     full_o;
  logic                     empty_o;

  // Upstream pipeline side: issues requests, consumes grants
  modport master (
    output enable_i, alloc_i, numInst_i, retire_i, retireNum_i, flush_i,
    input  allocValid_o, numInst_o, inst1RobId_o, inst2RobId_o,
           inst3RobId_o, inst4RobId_o, stall_o, retireErr_o,
           freeCount_o, full_o, empty_o
  );

  // Allocator side
  modport slave (
    input  enable_i, alloc_i, numInst_i, retire_i, retireNum_i, flush_i,
    output allocValid_o, numInst_o, inst1RobId_o, inst2RobId_o,
           inst3RobId_o, inst4RobId_o, stall_o, retireErr_o,
           freeCount_o, full_o, empty_o
  );
endinterface

// File: rtl/fx_rob_tag_alloc.sv
// rtl/fx_rob_tag_alloc.sv - circular ROB tag allocator, up to four tags per cycle
module fx_rob_tag_alloc #(
  parameter int ROBEntryWidth = 7
) (
  input  logic               clock_i,
  input  logic               reset_i,
  fx_rob_tag_alloc_if.slave  rob_if
);
  localparam int W  = ROBEntryWidth;
  localparam int CW = ROBEntryWidth + 1;
  localparam logic [CW-1:0] NUM_ENTRIES = {1'b1, {W{1'b0}}};

  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          alloc_valid_q, alloc_valid_d;
  logic [1:0]    num_inst_q, num_inst_d;
  logic [W-1:0]  tag_q [4];
  logic [W-1:0]  tag_d [4];
  logic          stall_q, stall_d;
  logic          retire_err_q, retire_err_d;

  logic [CW-1:0] req_n;
  logic [CW-1:0] ret_n;
  logic [CW-1:0] free_cnt;
  logic          alloc_req, alloc_ok;
  logic          ret_req, ret_ok;

  // Request decode; space is judged on the start-of-cycle count only
  always_comb begin
    req_n     = CW'(rob_if.numInst_i) + CW'(1);
    ret_n     = CW'(rob_if.retireNum_i) + CW'(1);
    free_cnt  = NUM_ENTRIES - count_q;
    alloc_req = rob_if.enable_i && rob_if.alloc_i && !rob_if.flush_i;
    alloc_ok  = alloc_req && (free_cnt >= req_n);
    ret_req   = rob_if.enable_i && rob_if.retire_i;
    ret_ok    = ret_req && (ret_n <= count_q);
  end

  // Next-state: retire moves head, allocate moves tail, flush collapses tail onto the new head
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    alloc_valid_d = alloc_ok;
    stall_d       = alloc_req && !alloc_ok;
    retire_err_d  = ret_req && !ret_ok;
    num_inst_d    = num_inst_q;
    for (int i = 0; i < 4; i++) begin
      tag_d[i] = tag_q[i];
    end

    if (ret_ok) begin
      head_d = head_q + ret_n[W-1:0];
    end

    if (rob_if.flush_i) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      count_d = count_q + (alloc_ok ? req_n : '0) - (ret_ok ? ret_n : '0);
      if (alloc_ok) begin
        tail_d     = tail_q + req_n[W-1:0];
        num_inst_d = rob_if.numInst_i;
        for (int i = 0; i < 4; i++) begin
          tag_d[i] = (2'(i) <= rob_if.numInst_i) ? tail_q + W'(i) : '0;
        end
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      alloc_valid_q <= 1'b0;
      num_inst_q    <= '0;
      stall_q       <= 1'b0;
      retire_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      alloc_valid_q <= alloc_valid_d;
      num_inst_q    <= num_inst_d;
      stall_q       <= stall_d;
      retire_err_q  <= retire_err_d;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rob_if.allocValid_o = alloc_valid_q;
  assign rob_if.numInst_o    = num_inst_q;
  assign rob_if.inst1RobId_o = tag_q[0];
  assign rob_if.inst2RobId_o = tag_q[1];
  assign rob_if.inst3RobId_o = tag_q[2];
  assign rob_if.inst4RobId_o = tag_q[3];
  assign rob_if.stall_o      = stall_q;
  assign rob_if.retireErr_o  = retire_err_q;
  assign rob_if.freeCount_o  = free_cnt;
  assign rob_if.full_o       = (count_q == NUM_ENTRIES);
  assign rob_if.empty_o      = (count_q == '0);
endmodule
